// File: rtl/led_seq_pkg.sv
// Shared types and constants for the LED sequencer: pattern modes, FSM states, counter widths.
package led_seq_pkg;

  localparam int unsigned CNT_W  = 26;
  localparam int unsigned STEP_W = 5;

  typedef enum logic [1:0] {
    MODE_BLINK   = 2'd0,
    MODE_CHASE_L = 2'd1,
    MODE_CHASE_R = 2'd2,
    MODE_BOUNCE  = 2'd3
  } mode_e;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_FINISH = 2'd2,
    ST_PAUSED = 2'd3
  } state_e;

  // Index of the final step of one pattern pass for an n-LED strip.
  function automatic logic [STEP_W-1:0] last_step(mode_e m, int unsigned n);
    case (m)
      MODE_BLINK:                last_step = STEP_W'(1);
      MODE_CHASE_L, MODE_CHASE_R: last_step = STEP_W'(n - 1);
      default:                   last_step = STEP_W'(2 * n - 3);
    endcase
  endfunction

endpackage

// File: rtl/led_tick_gen.sv
// Step-rate divider: counts 0..div-1 while enabled and flags the final count.
module led_tick_gen
  import led_seq_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  input  logic [CNT_W-1:0] div,
  output logic             tick
);

  logic [CNT_W-1:0] cnt;
  logic             at_end_c;

  assign at_end_c = (cnt == div - CNT_W'(1));
  assign tick     = en && at_end_c;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= at_end_c ? '0 : cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/led_seq_ctrl.sv
// LED pattern sequencer: runs BLINK/CHASE/BOUNCE passes at a selectable step rate.
// Define LED_SEQ_PAUSE_EN to add the pause input and the PAUSED state.
module led_seq_ctrl
  import led_seq_pkg::*;
#(
  parameter int unsigned N_LED = 8,
  parameter int unsigned DIV_0 = 50_000_000,
  parameter int unsigned DIV_1 = 25_000_000,
  parameter int unsigned DIV_2 = 10_000_000,
  parameter int unsigned DIV_3 = 4
) (
  input  logic             clk,
  input  logic             rst,
`ifdef LED_SEQ_PAUSE_EN
  input  logic             pause,
`endif
  input  logic             start,
  input  logic             stop,
  input  logic [1:0]       mode,
  input  logic [1:0]       rate_sel,
  input  logic [3:0]       reps,
  output logic [N_LED-1:0] led,
  output logic             busy,
  output logic             pass_done,
  output logic             done
);

  localparam logic [1:0] S_IDLE   = ST_IDLE;
  localparam logic [1:0] S_RUN    = ST_RUN;
  localparam logic [1:0] S_FINISH = ST_FINISH;
`ifdef LED_SEQ_PAUSE_EN
  localparam logic [1:0] S_PAUSED = ST_PAUSED;
`endif

  logic [1:0]        state, state_nxt;
  mode_e             mode_q, mode_nxt;
  logic [1:0]        rate_q, rate_nxt;
  logic [3:0]        reps_q, reps_nxt;
  logic [3:0]        pass_q, pass_nxt;
  logic [4:0]        pass_inc;
  logic [STEP_W-1:0] step_q, step_nxt;
  logic [N_LED-1:0]  led_nxt;
  logic              busy_nxt, pass_done_nxt, done_nxt;
  logic [CNT_W-1:0]  div_c;
  logic              tick, tick_en_c, tick_clr_c;

  function automatic logic [N_LED-1:0] led_pattern(mode_e m, logic [STEP_W-1:0] s);
    case (m)
      MODE_BLINK:   led_pattern = (s == '0) ? '1 : '0;
      MODE_CHASE_L: led_pattern = N_LED'(1) << s;
      MODE_CHASE_R: led_pattern = N_LED'(1) << (STEP_W'(N_LED - 1) - s);
      default:      led_pattern = (s < STEP_W'(N_LED)) ? N_LED'(1) << s
                                  : N_LED'(1) << (STEP_W'(2 * N_LED - 2) - s);
    endcase
  endfunction

  always_comb begin
    case (rate_q)
      2'd0:    div_c = CNT_W'(DIV_0);
      2'd1:    div_c = CNT_W'(DIV_1);
      2'd2:    div_c = CNT_W'(DIV_2);
      default: div_c = CNT_W'(DIV_3);
    endcase
  end

  // Counter only advances in RUN; it is parked at zero whenever no pass is in progress.
  assign tick_en_c  = (state == S_RUN) && !stop;
  assign tick_clr_c = (state == S_IDLE) || (state == S_FINISH) || stop;
  assign pass_inc   = {1'b0, pass_q} + 5'd1;

  led_tick_gen u_tick (
    .clk  (clk),
    .rst  (rst),
    .clr  (tick_clr_c),
    .en   (tick_en_c),
    .div  (div_c),
    .tick (tick)
  );

  always_comb begin
    state_nxt     = state;
    mode_nxt      = mode_q;
    rate_nxt      = rate_q;
    reps_nxt      = reps_q;
    step_nxt      = step_q;
    pass_nxt      = pass_q;
    pass_done_nxt = 1'b0;
    done_nxt      = 1'b0;
    case (state)
      S_IDLE: begin
        if (start && !stop) begin
          mode_nxt  = mode_e'(mode);
          rate_nxt  = rate_sel;
          reps_nxt  = reps;
          step_nxt  = '0;
          pass_nxt  = '0;
          state_nxt = S_RUN;
        end
      end
      S_RUN: begin
        if (stop) begin
          state_nxt = S_IDLE;
        end else begin
          if (tick) begin
            if (step_q == last_step(mode_q, N_LED)) begin
              pass_done_nxt = 1'b1;
              step_nxt      = '0;
              pass_nxt      = (pass_q == 4'hF) ? pass_q : pass_inc[3:0];
              if (reps_q != 4'd0 && pass_inc == {1'b0, reps_q}) begin
                state_nxt = S_FINISH;
                done_nxt  = 1'b1;
              end
            end else begin
              step_nxt = step_q + STEP_W'(1);
            end
          end
`ifdef LED_SEQ_PAUSE_EN
          if (pause && state_nxt == S_RUN) state_nxt = S_PAUSED;
`endif
        end
      end
`ifdef LED_SEQ_PAUSE_EN
      S_PAUSED: begin
        if (stop)        state_nxt = S_IDLE;
        else if (!pause) state_nxt = S_RUN;
      end
`endif
      S_FINISH: state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
    busy_nxt = (state_nxt != S_IDLE);
    led_nxt  = (state_nxt == S_IDLE || state_nxt == S_FINISH) ? '0
               : led_pattern(mode_nxt, step_nxt);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      mode_q    <= MODE_BLINK;
      rate_q    <= '0;
      reps_q    <= '0;
      step_q    <= '0;
      pass_q    <= '0;
      led       <= '0;
      busy      <= 1'b0;
      pass_done <= 1'b0;
      done      <= 1'b0;
    end else begin
      state     <= state_nxt;
      mode_q    <= mode_nxt;
      rate_q    <= rate_nxt;
      reps_q    <= reps_nxt;
      step_q    <= step_nxt;
      pass_q    <= pass_nxt;
      led       <= led_nxt;
      busy      <= busy_nxt;
      pass_done <= pass_done_nxt;
      done      <= done_nxt;
    end
  end

endmodule

// File: tb/tb_led_seq_ctrl.sv
// Randomized bench for led_seq_ctrl: expected per-cycle traces built from the pattern rules.
// Exercises the pause path when LED_SEQ_PAUSE_EN is defined.
module tb_led_seq_ctrl;

  localparam int N  = 8;
  localparam int D0 = 7;
  localparam int D1 = 3;
  localparam int D2 = 1;
  localparam int D3 = 4;

  logic         clk = 1'b0;
  logic         rst, start, stop;
  logic [1:0]   mode, rate_sel;
  logic [3:0]   reps;
  logic [N-1:0] led;
  logic         busy, pass_done, done;
`ifdef LED_SEQ_PAUSE_EN
  logic         pause;
  int           pause_left = 0;
`endif

  typedef struct {
    logic [N-1:0] led;
    logic         busy;
    logic         pd;
    logic         dn;
  } exp_t;

  exp_t trace[$];
  exp_t idle_e = '{led: '0, busy: 1'b0, pd: 1'b0, dn: 1'b0};
  int   n_cmp = 0;
  int   n_bad = 0;

  led_seq_ctrl #(.N_LED(N), .DIV_0(D0), .DIV_1(D1), .DIV_2(D2), .DIV_3(D3)) dut (
    .clk       (clk),
    .rst       (rst),
`ifdef LED_SEQ_PAUSE_EN
    .pause     (pause),
`endif
    .start     (start),
    .stop      (stop),
    .mode      (mode),
    .rate_sel  (rate_sel),
    .reps      (reps),
    .led       (led),
    .busy      (busy),
    .pass_done (pass_done),
    .done      (done)
  );

  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h (t=%0t)", tag, got, want, $time);
    end
  endtask

  task automatic check_cycle(input exp_t e, input string where);
    check({where, " led"},       32'(led),       32'(e.led));
    check({where, " busy"},      32'(busy),      32'(e.busy));
    check({where, " pass_done"}, 32'(pass_done), 32'(e.pd));
    check({where, " done"},      32'(done),      32'(e.dn));
  endtask

  function automatic int div_of(int r);
    case (r)
      0: return D0;
      1: return D1;
      2: return D2;
      default: return D3;
    endcase
  endfunction

  function automatic int steps_of(int m);
    return (m == 0) ? 2 : (m == 3) ? 2 * N - 2 : N;
  endfunction

  // Lit position from the pattern description; bounce is a triangle wave over 0..N-1.
  function automatic logic [N-1:0] pat(int m, int s);
    logic [N-1:0] p;
    int idx;
    p = '0;
    if (m == 0) return (s == 0) ? '1 : '0;
    if (m == 1)      idx = s;
    else if (m == 2) idx = N - 1 - s;
    else             idx = (N - 1) - ((s > N - 1) ? s - (N - 1) : (N - 1) - s);
    p[idx] = 1'b1;
    return p;
  endfunction

  task automatic build_trace(input int m, input int r, input int rp, input int min_len);
    int per_pass, passes;
    exp_t e;
    per_pass = steps_of(m) * div_of(r);
    passes   = (rp != 0) ? rp : min_len / per_pass + 2;
    trace.delete();
    for (int p = 0; p < passes; p++)
      for (int s = 0; s < steps_of(m); s++)
        for (int c = 0; c < div_of(r); c++) begin
          e.led  = pat(m, s);
          e.busy = 1'b1;
          e.pd   = (p > 0 && s == 0 && c == 0);
          e.dn   = 1'b0;
          trace.push_back(e);
        end
    if (rp != 0) begin
      trace.push_back('{led: '0, busy: 1'b1, pd: 1'b1, dn: 1'b1});
      trace.push_back(idle_e);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
`ifdef LED_SEQ_PAUSE_EN
    if (pause_left > 0) begin
      pause_left--;
      if (pause_left == 0) pause = 1'b0;
    end
`endif
  endtask

  // abort_kind: 0 none, 1 stop, 2 reset (two cycles) after trace index abort_at
  task automatic run_seq(input int m, input int r, input int rp, input int abort_kind,
                         input int abort_at, input int spur_pct, input int pause_pct);
    string where;
    int pause_end;
    pause_end = -1;
    build_trace(m, r, rp, abort_at + 1);
    mode = 2'(m); rate_sel = 2'(r); reps = 4'(rp); start = 1'b1; stop = 1'b0;
    next_cycle();
    start = 1'b0;
    for (int i = 0; i < trace.size(); i++) begin
      where = $sformatf("m%0d r%0d n%0d c%0d", m, r, rp, i);
      check_cycle(trace[i], where);
      mode = 2'($urandom); rate_sel = 2'($urandom); reps = 4'($urandom);
      start = trace[i].busy && ($urandom_range(0, 99) < spur_pct);
      if (abort_kind != 0 && i == abort_at) begin
        if (abort_kind == 1) begin
          stop = 1'b1;
          next_cycle();
          stop = 1'b0; start = 1'b0;
          check_cycle(idle_e, {where, " after stop"});
        end else begin
          rst = 1'b1;
          next_cycle();
          start = 1'b0;
          check_cycle(idle_e, {where, " rst1"});
          next_cycle();
          check_cycle(idle_e, {where, " rst2"});
          rst = 1'b0;
        end
`ifdef LED_SEQ_PAUSE_EN
        pause = 1'b0; pause_left = 0;
`endif
        return;
      end
`ifdef LED_SEQ_PAUSE_EN
      if (i > pause_end && i + 2 < trace.size() && trace[i].busy && !trace[i].dn &&
          trace[i+1].busy && !trace[i+1].dn && $urandom_range(0, 99) < pause_pct) begin
        int plen;
        exp_t frz;
        plen = $urandom_range(1, 10);
        frz = trace[i+1];
        frz.pd = 1'b0;
        frz.dn = 1'b0;
        for (int k = 0; k < plen; k++) trace.insert(i + 2, frz);
        pause = 1'b1;
        pause_left = plen;
        pause_end = i + plen + 1;
      end
`else
      if (pause_pct < 0) pause_end = i;
`endif
      next_cycle();
      start = 1'b0;
    end
`ifdef LED_SEQ_PAUSE_EN
    pause = 1'b0; pause_left = 0;
`endif
  endtask

  // start together with stop while idle must leave the block idle
  task automatic idle_collision();
    start = 1'b1; stop = 1'b1; mode = 2'($urandom);
    next_cycle();
    start = 1'b0; stop = 1'b0;
    check_cycle(idle_e, "start+stop idle");
  endtask

  initial begin
    int m, r, rp, kind, at, est;
    rst = 1'b1; start = 1'b0; stop = 1'b0; mode = '0; rate_sel = '0; reps = '0;
`ifdef LED_SEQ_PAUSE_EN
    pause = 1'b0;
`endif
    repeat (3) @(posedge clk);
    #1;
    start = 1'b1;
    next_cycle();
    check_cycle(idle_e, "reset held with start");
    start = 1'b0; rst = 1'b0;
    next_cycle();
    check_cycle(idle_e, "after reset");

    run_seq(1, 3, 1, 0, 0, 0, 0);
    run_seq(3, 3, 2, 0, 0, 0, 0);
    run_seq(0, 3, 0, 1, 19, 0, 0);
    run_seq(1, 3, 3, 2, 13, 0, 0);
    run_seq(1, 3, 1, 0, 0, 0, 0);
    run_seq(2, 3, 2, 0, 0, 40, 0);
    idle_collision();
    run_seq(2, 2, 1, 0, 0, 0, 0);
`ifdef LED_SEQ_PAUSE_EN
    run_seq(2, 3, 1, 0, 0, 0, 30);
`endif

    for (int n = 0; n < 40; n++) begin
      m  = $urandom_range(0, 3);
      r  = $urandom_range(0, 3);
      rp = $urandom_range(0, 3);
      est = (rp != 0) ? rp * steps_of(m) * div_of(r) + 1 : 120;
      kind = (rp == 0) ? $urandom_range(1, 2)
           : (($urandom_range(0, 1) == 0) ? 0 : $urandom_range(1, 2));
      at = $urandom_range(0, est - 1);
      run_seq(m, r, rp, kind, at, 10, 10);
      if ($urandom_range(0, 2) == 0) idle_collision();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/led_seq_ctrl.md
LED_SEQ_CTRL -- requirements
Module: led_seq_ctrl

Interface
REQ-001 SHALL have parameter N_LED, default 8, number of LED outputs (4..16).
REQ-002 SHALL have parameters DIV_0/DIV_1/DIV_2/DIV_3, defaults 50_000_000/25_000_000/10_000_000/4, clk cycles per step tick for rate_sel 0..3.
REQ-003 SHALL have port clk  input  1  system clock; all logic on rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port start  input  1  single-cycle request to begin a sequence.
REQ-006 SHALL have port stop  input  1  single-cycle abort request.
REQ-007 SHALL have port mode  input  2  pattern: 0 BLINK, 1 CHASE_L, 2 CHASE_R, 3 BOUNCE.
REQ-008 SHALL have port rate_sel  input  2  selects DIV_n.
REQ-009 SHALL have port reps  input  4  pattern passes to run; 0 = run until stop.
REQ-010 SHALL have port led  output  N_LED  registered LED drive.
REQ-011 SHALL have port busy  output  1  high while not IDLE.
REQ-012 SHALL have ports pass_done and done, output, 1 each: one-cycle pulses at end of each pass / end of sequence.

Function
REQ-013 SHALL implement states IDLE, RUN, FINISH (plus PAUSED, see Configuration).
REQ-014 IDLE: start=1 and stop=0 at edge t SHALL latch mode, rate_sel, reps, clear tick counter and step index; at t+1 state=RUN, busy=1, led=step-0 pattern.
REQ-015 Tick counter SHALL count 0..DIV_sel-1 in RUN, raising tick for one cycle at DIV_sel-1 and wrapping to 0; step advances on the edge after tick, so each step holds exactly DIV_sel cycles.
REQ-016 Patterns: BLINK 2 steps (all ones, all zeros); CHASE_L N_LED steps one-hot from bit0 upward; CHASE_R N_LED steps one-hot from bit N_LED-1 downward; BOUNCE 2*N_LED-2 steps bit0 up to bit N_LED-1 and back, endpoints not repeated.
REQ-017 On tick at the last step SHALL pulse pass_done, wrap step to 0, increment pass counter (4 bits).
REQ-018 When reps!=0 and pass counter reaches reps, SHALL enter FINISH instead of wrapping; FINISH lasts one cycle, led=0, done=1, then IDLE.
REQ-019 reps=0 SHALL run indefinitely; pass counter saturates at 15.
REQ-020 stop in RUN/PAUSED SHALL force IDLE next cycle, led=0, busy=0, no done pulse.
REQ-021 start while busy SHALL be ignored; latched config SHALL not change mid-sequence.
REQ-022 start and stop together in IDLE: stop wins, stay IDLE.
REQ-023 In IDLE led SHALL be 0 and tick counter held at 0.

Reset
REQ-024 rst=1 at any edge SHALL force IDLE, led=0, busy=0, pass_done=0, done=0, all counters and latched config 0, overriding start/stop.
REQ-025 Reset mid-sequence SHALL abort without done pulse; start accepted the first edge after rst deasserts.

Configuration
REQ-026 With macro LED_SEQ_PAUSE_EN defined, SHALL add input pause (1 bit) and state PAUSED: pause=1 in RUN enters PAUSED, freezing tick counter, step, led; pause=0 returns to RUN and resumes the same count; stop from PAUSED per REQ-020.
REQ-027 Without LED_SEQ_PAUSE_EN, port pause and state PAUSED SHALL not exist; behaviour otherwise identical.

Structure
REQ-028 Package led_seq_pkg SHALL hold the mode enum, state enum, and DIV counter width constant (26 bits).
REQ-029 Tick counter SHALL be sub-module led_tick_gen (inputs clk, rst, clr, en, div; output tick); pattern generation and FSM stay in led_seq_ctrl.

Verification
REQ-030 Reset: rst high 2 cycles mid-CHASE_L -> led=0, busy=0, no done; start next cycle accepted.
REQ-031 CHASE_L, N_LED=8, rate_sel=3 (DIV=4), reps=1 -> led 0x01,0x02..0x80 each 4 cycles, pass_done and done once, busy falls after 33 cycles.
REQ-032 BOUNCE, reps=2, DIV=4 -> 14-step pass 0x01..0x80..0x02, two pass_done pulses 56 cycles apart, then done.
REQ-033 BLINK reps=0, stop after 20 cycles -> led alternates 0xFF/0x00 every 4 cycles, IDLE next cycle, no done.
REQ-034 start during RUN with different mode, and start+stop together in IDLE -> both ignored, pattern and state unchanged.
REQ-035 With LED_SEQ_PAUSE_EN: pause 10 cycles mid-step in CHASE_R -> led frozen, remaining step cycles resume exactly after release.
